// File: rtl/wash_cycle_ctrl.sv
// Wash machine master sequencer: fill, wash, drain, N rinse passes, spin.
// Drives the phase timer and the actuators; every output is registered.
module wash_cycle_ctrl #(
  parameter int RINSE_CYCLES = 1,
  parameter int GUARD        = 1
) (
  input  logic       clk,
  input  logic       R_n,
  input  logic       start,
  input  logic       lid_open,
  input  logic       abort,
  input  logic       Tf,
  input  logic       Tw,
  input  logic       Td,
  input  logic       Tr,
  input  logic       Ts,
  output logic [1:0] tmr_load,
  output logic       tmr_R,
  output logic       tmr_hold,
  output logic       water_in,
  output logic       agitate,
  output logic       pump,
  output logic       spinner,
  output logic       busy,
  output logic       done,
  output logic [3:0] state,
  output logic [1:0] rinse_cnt
);

  // state  | meaning
  // IDLE   | waiting for start, timer held restarted
  // FILL   | main fill, valve open
  // WASH   | agitating
  // DRAIN  | pumping out wash water
  // RFILL  | rinse fill
  // RINSE  | rinse agitation
  // RDRAIN | pumping out rinse water, counts the pass
  // SPIN   | spinning, paused while the lid is open
  // DONE   | cycle complete, waits for start to drop
  // ADRAIN | abort drain, returns to IDLE
  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FILL   = 4'd1,
    WASH   = 4'd2,
    DRAIN  = 4'd3,
    RFILL  = 4'd4,
    RINSE  = 4'd5,
    RDRAIN = 4'd6,
    SPIN   = 4'd7,
    DONE   = 4'd8,
    ADRAIN = 4'd9
  } state_t;

  localparam int GW = $clog2(GUARD + 2);
  localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD + 1);
  localparam logic [2:0]    RC_LIMIT   = 3'(RINSE_CYCLES);

  state_t        cur, nxt;
  logic [GW-1:0] gcnt;
  logic          armed;
  logic [1:0]    tmr_load_d, rinse_cnt_d;
  logic          tmr_r_d, tmr_hold_d, water_d, agit_d, pump_d, spin_d, busy_d, done_d;

  // Guard counter reaches zero only after the entry cycle plus GUARD cycles.
  assign armed = (gcnt == '0);
  assign state = cur;

  always_ff @(posedge clk or negedge R_n) begin
    if (!R_n) begin
      cur       <= IDLE;
      gcnt      <= '0;
      tmr_load  <= 2'b00;
      tmr_R     <= 1'b1;
      tmr_hold  <= 1'b0;
      water_in  <= 1'b0;
      agitate   <= 1'b0;
      pump      <= 1'b0;
      spinner   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rinse_cnt <= 2'b00;
    end else begin
      cur       <= nxt;
      if (nxt != cur)  gcnt <= GUARD_LOAD;
      else if (!armed) gcnt <= gcnt - GW'(1);
      tmr_load  <= tmr_load_d;
      tmr_R     <= tmr_r_d;
      tmr_hold  <= tmr_hold_d;
      water_in  <= water_d;
      agitate   <= agit_d;
      pump      <= pump_d;
      spinner   <= spin_d;
      busy      <= busy_d;
      done      <= done_d;
      rinse_cnt <= rinse_cnt_d;
    end
  end

  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:    if (start)         nxt = FILL;
      FILL:    if (armed && Tf)   nxt = WASH;
      WASH:    if (armed && Tw)   nxt = DRAIN;
      DRAIN:   if (armed && Td)   nxt = RFILL;
      RFILL:   if (armed && Tf)   nxt = RINSE;
      RINSE:   if (armed && Tr)   nxt = RDRAIN;
      RDRAIN:  if (armed && Td)   nxt = (({1'b0, rinse_cnt} + 3'd1) < RC_LIMIT) ? RFILL : SPIN;
      SPIN:    if (armed && Ts && !lid_open) nxt = DONE;
      DONE:    if (!start)        nxt = IDLE;
      ADRAIN:  if (armed && Td)   nxt = IDLE;
      default:                    nxt = IDLE;
    endcase
    // Abort overrides any expiry seen in the same cycle.
    if (abort && (cur inside {FILL, WASH, DRAIN, RFILL, RINSE, RDRAIN, SPIN}))
      nxt = ADRAIN;
  end

  always_comb begin
    tmr_load_d  = 2'b00;
    tmr_r_d     = (nxt != cur) || (nxt == IDLE) || (nxt == DONE);
    tmr_hold_d  = 1'b0;
    water_d     = 1'b0;
    agit_d      = 1'b0;
    pump_d      = 1'b0;
    spin_d      = 1'b0;
    busy_d      = 1'b1;
    done_d      = 1'b0;
    rinse_cnt_d = rinse_cnt;
    case (nxt)
      IDLE: begin
        busy_d      = 1'b0;
        rinse_cnt_d = 2'b00;
      end
      FILL, RFILL:           water_d = 1'b1;
      WASH: begin
        tmr_load_d = 2'b01;
        agit_d     = 1'b1;
      end
      DRAIN, RDRAIN, ADRAIN: pump_d = 1'b1;
      RINSE: begin
        tmr_load_d = 2'b10;
        agit_d     = 1'b1;
      end
      SPIN: begin
        tmr_load_d = 2'b11;
        pump_d     = 1'b1;
        spin_d     = !lid_open;
        tmr_hold_d = lid_open;
      end
      DONE: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: busy_d = 1'b0;
    endcase
    if (cur == RDRAIN && (nxt == RFILL || nxt == SPIN))
      rinse_cnt_d = rinse_cnt + 2'd1;
  end

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Bench for wash_cycle_ctrl: two instances (1 and 3 rinse passes) driven by
// randomized flag timing and checked against a phase-list reference model.
module tb_wash_cycle_ctrl;
  localparam int RC_A = 1, G_A = 1;
  localparam int RC_B = 3, G_B = 2;

  logic clk = 1'b0;
  logic R_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic lid_open = 1'b0, abort = 1'b0;
  logic Tf = 1'b0, Tw = 1'b0, Td = 1'b0, Tr = 1'b0, Ts = 1'b0;

  logic [1:0] a_load, b_load, a_rcnt, b_rcnt;
  logic [3:0] a_state, b_state;
  logic a_R, a_hold, a_water, a_agit, a_pump, a_spin, a_busy, a_done;
  logic b_R, b_hold, b_water, b_agit, b_pump, b_spin, b_busy, b_done;

  logic [1:0] o_load, o_rcnt;
  logic [3:0] o_state, o_act;
  logic o_R, o_hold, o_busy, o_done;

  bit sel;
  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  wash_cycle_ctrl #(.RINSE_CYCLES(RC_A), .GUARD(G_A)) dut_a (
    .clk(clk), .R_n(R_n), .start(start_a), .lid_open(lid_open), .abort(abort),
    .Tf(Tf), .Tw(Tw), .Td(Td), .Tr(Tr), .Ts(Ts),
    .tmr_load(a_load), .tmr_R(a_R), .tmr_hold(a_hold),
    .water_in(a_water), .agitate(a_agit), .pump(a_pump), .spinner(a_spin),
    .busy(a_busy), .done(a_done), .state(a_state), .rinse_cnt(a_rcnt));

  wash_cycle_ctrl #(.RINSE_CYCLES(RC_B), .GUARD(G_B)) dut_b (
    .clk(clk), .R_n(R_n), .start(start_b), .lid_open(lid_open), .abort(abort),
    .Tf(Tf), .Tw(Tw), .Td(Td), .Tr(Tr), .Ts(Ts),
    .tmr_load(b_load), .tmr_R(b_R), .tmr_hold(b_hold),
    .water_in(b_water), .agitate(b_agit), .pump(b_pump), .spinner(b_spin),
    .busy(b_busy), .done(b_done), .state(b_state), .rinse_cnt(b_rcnt));

  always_comb begin
    if (sel) begin
      o_state = b_state; o_load = b_load; o_R = b_R; o_hold = b_hold;
      o_act = {b_water, b_agit, b_pump, b_spin};
      o_busy = b_busy; o_done = b_done; o_rcnt = b_rcnt;
    end else begin
      o_state = a_state; o_load = a_load; o_R = a_R; o_hold = a_hold;
      o_act = {a_water, a_agit, a_pump, a_spin};
      o_busy = a_busy; o_done = a_done; o_rcnt = a_rcnt;
    end
  end

  // Reference model: per-state timer interval and actuator pattern.
  function automatic logic [1:0] exp_load(input int st);
    case (st)
      2:       return 2'b01;
      5:       return 2'b10;
      7:       return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] exp_act(input int st, input bit lid);
    logic w, a, p, s;
    w = (st == 1) || (st == 4);
    a = (st == 2) || (st == 5);
    p = (st == 3) || (st == 6) || (st == 7) || (st == 9);
    s = (st == 7) && !lid;
    return {w, a, p, s};
  endfunction

  function automatic int guard_of(input bit s);
    return s ? G_B : G_A;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clr_flags();
    Tf = 1'b0; Tw = 1'b0; Td = 1'b0; Tr = 1'b0; Ts = 1'b0;
  endtask

  task automatic set_flag(input int st, input logic v);
    case (st)
      1, 4:    Tf = v;
      2:       Tw = v;
      3, 6, 9: Td = v;
      5:       Tr = v;
      7:       Ts = v;
      default: ;
    endcase
  endtask

  task automatic set_start(input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  // Advance the selected instance to a target state, holding each phase flag.
  task automatic run_to(input int target, input bit hold_start);
    int n;
    n = 0;
    while (int'(o_state) != target && n < 400) begin
      clr_flags();
      if (o_state == 4'd0) set_start(1'b1);
      else if (!hold_start) set_start(1'b0);
      set_flag(int'(o_state), 1'b1);
      tick();
      n++;
    end
    clr_flags();
    if (!hold_start) set_start(1'b0);
    checks++;
    if (int'(o_state) !== target)
      $display("FAIL run_to: state=%0d required=%0d", o_state, target);
    else passed++;
  endtask

  task automatic test_reset();
    R_n = 1'b0;
    repeat (2) tick();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      checks++;
      if ({o_state, o_R, o_load, o_hold, o_act, o_busy, o_done, o_rcnt} !== 15'b0000_1_00_0_0000_0_0_00)
        $display("FAIL reset[%0d]: got %h required %h", s,
                 {o_state, o_R, o_load, o_hold, o_act, o_busy, o_done, o_rcnt}, 15'b0000_1_00_0_0000_0_0_00);
      else passed++;
    end
    R_n = 1'b1;
    sel = 1'b0;
    tick();
    checks++;
    if ({o_state, o_R, o_busy} !== {4'd0, 1'b1, 1'b0})
      $display("FAIL idle_after_reset: got %h required %h", {o_state, o_R, o_busy}, {4'd0, 1'b1, 1'b0});
    else passed++;
  endtask

  task automatic test_full_cycle(input bit s);
    int seq[$];
    int rc, g, rdone, st, d;
    sel = s;
    rc = s ? RC_B : RC_A;
    g = guard_of(s);
    seq = {};
    seq.push_back(1); seq.push_back(2); seq.push_back(3);
    for (int k = 0; k < rc; k++) begin
      seq.push_back(4); seq.push_back(5); seq.push_back(6);
    end
    seq.push_back(7); seq.push_back(8);
    set_start(1'b1);
    tick();
    set_start(1'b0);
    rdone = 0;
    for (int i = 0; i < seq.size() - 1; i++) begin
      st = seq[i];
      checks++;
      if ({o_state, o_load, o_R, o_hold} !== {4'(st), exp_load(st), 1'b1, 1'b0})
        $display("FAIL entry[%0d] st=%0d: got %h required %h", i, st,
                 {o_state, o_load, o_R, o_hold}, {4'(st), exp_load(st), 1'b1, 1'b0});
      else passed++;
      checks++;
      if ({o_act, o_busy, o_done, o_rcnt} !== {exp_act(st, 1'b0), 1'b1, 1'b0, 2'(rdone)})
        $display("FAIL outputs[%0d] st=%0d: got %h required %h", i, st,
                 {o_act, o_busy, o_done, o_rcnt}, {exp_act(st, 1'b0), 1'b1, 1'b0, 2'(rdone)});
      else passed++;
      // Random flag pulses inside the guard window must be dropped.
      for (int j = 0; j <= g; j++) begin
        set_flag(st, 1'($urandom_range(0, 1)));
        tick();
        clr_flags();
        checks++;
        if ({o_state, o_R} !== {4'(st), 1'b0})
          $display("FAIL guard[%0d] st=%0d: got %h required %h", j, st, {o_state, o_R}, {4'(st), 1'b0});
        else passed++;
      end
      d = $urandom_range(0, 3);
      repeat (d) tick();
      checks++;
      if (o_state !== 4'(st))
        $display("FAIL hold st=%0d: got %0d required %0d", st, o_state, st);
      else passed++;
      set_flag(st, 1'b1);
      tick();
      clr_flags();
      if (st == 6) rdone++;
      checks++;
      if (o_state !== 4'(seq[i + 1]))
        $display("FAIL advance from %0d: got %0d required %0d", st, o_state, seq[i + 1]);
      else passed++;
    end
    checks++;
    if ({o_act, o_busy, o_done, o_rcnt} !== {4'b0000, 1'b0, 1'b1, 2'(rc)})
      $display("FAIL done_outputs: got %h required %h", {o_act, o_busy, o_done, o_rcnt},
               {4'b0000, 1'b0, 1'b1, 2'(rc)});
    else passed++;
    tick();
    checks++;
    if ({o_state, o_done, o_rcnt} !== {4'd0, 1'b0, 2'b00})
      $display("FAIL done_to_idle: got %h required %h", {o_state, o_done, o_rcnt}, {4'd0, 1'b0, 2'b00});
    else passed++;
  endtask

  task automatic test_lid();
    int g;
    sel = 1'b0;
    g = guard_of(sel);
    run_to(2, 1'b0);
    lid_open = 1'b1;
    tick();
    checks++;
    if ({o_state, o_hold, o_act} !== {4'd2, 1'b0, exp_act(2, 1'b1)})
      $display("FAIL lid_outside_spin: got %h required %h", {o_state, o_hold, o_act}, {4'd2, 1'b0, exp_act(2, 1'b1)});
    else passed++;
    lid_open = 1'b0;
    run_to(7, 1'b0);
    repeat (g + 1) tick();
    checks++;
    if ({o_hold, o_spin_bit()} !== 2'b01)
      $display("FAIL spin_running: got %b required 01", {o_hold, o_spin_bit()});
    else passed++;
    lid_open = 1'b1;
    Ts = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if ({o_state, o_hold, o_act} !== {4'd7, 1'b1, exp_act(7, 1'b1)})
        $display("FAIL lid_open[%0d]: got %h required %h", k, {o_state, o_hold, o_act}, {4'd7, 1'b1, exp_act(7, 1'b1)});
      else passed++;
    end
    lid_open = 1'b0;
    Ts = 1'b0;
    tick();
    checks++;
    if ({o_state, o_hold, o_act} !== {4'd7, 1'b0, exp_act(7, 1'b0)})
      $display("FAIL lid_closed: got %h required %h", {o_state, o_hold, o_act}, {4'd7, 1'b0, exp_act(7, 1'b0)});
    else passed++;
    Ts = 1'b1;
    tick();
    Ts = 1'b0;
    checks++;
    if ({o_state, o_done} !== {4'd8, 1'b1})
      $display("FAIL spin_to_done: got %h required %h", {o_state, o_done}, {4'd8, 1'b1});
    else passed++;
    tick();
  endtask

  function automatic logic o_spin_bit();
    return o_act[0];
  endfunction

  task automatic test_abort();
    int g, tgt, st;
    for (int r = 0; r < 6; r++) begin
      sel = (r == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      g = guard_of(sel);
      tgt = (r == 0) ? 2 : $urandom_range(1, 7);
      run_to(tgt, 1'b0);
      repeat ((r == 0) ? g + 1 : $urandom_range(0, 4)) tick();
      st = int'(o_state);
      abort = 1'b1;
      set_flag(st, (r == 0) ? 1'b1 : 1'($urandom_range(0, 1)));
      tick();
      abort = 1'b0;
      clr_flags();
      checks++;
      if ({o_state, o_R, o_load, o_act, o_busy, o_done} !== {4'd9, 1'b1, 2'b00, exp_act(9, 1'b0), 1'b1, 1'b0})
        $display("FAIL abort_from_%0d: got %h required %h", st, {o_state, o_R, o_load, o_act, o_busy, o_done},
                 {4'd9, 1'b1, 2'b00, exp_act(9, 1'b0), 1'b1, 1'b0});
      else passed++;
      Td = 1'b1;
      for (int k = 0; k <= g; k++) begin
        tick();
        checks++;
        if ({o_state, o_R} !== {4'd9, 1'b0})
          $display("FAIL adrain_guard[%0d]: got %h required %h", k, {o_state, o_R}, {4'd9, 1'b0});
        else passed++;
      end
      tick();
      Td = 1'b0;
      checks++;
      if ({o_state, o_busy, o_done, o_rcnt, o_act} !== {4'd0, 1'b0, 1'b0, 2'b00, 4'b0000})
        $display("FAIL adrain_to_idle: got %h required %h", {o_state, o_busy, o_done, o_rcnt, o_act},
                 {4'd0, 1'b0, 1'b0, 2'b00, 4'b0000});
      else passed++;
    end
    abort = 1'b1;
    repeat (3) tick();
    abort = 1'b0;
    checks++;
    if (o_state !== 4'd0)
      $display("FAIL abort_in_idle: got %0d required 0", o_state);
    else passed++;
  endtask

  task automatic test_guard_held();
    int g;
    sel = 1'b1;
    g = guard_of(sel);
    set_start(1'b1);
    tick();
    set_start(1'b0);
    Tf = 1'b1;
    for (int k = 0; k <= g; k++) begin
      tick();
      checks++;
      if ({o_state, o_R} !== {4'd1, 1'b0})
        $display("FAIL held_flag_guard[%0d]: got %h required %h", k, {o_state, o_R}, {4'd1, 1'b0});
      else passed++;
    end
    tick();
    Tf = 1'b0;
    checks++;
    if ({o_state, o_R, o_load} !== {4'd2, 1'b1, 2'b01})
      $display("FAIL held_flag_advance: got %h required %h", {o_state, o_R, o_load}, {4'd2, 1'b1, 2'b01});
    else passed++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    run_to(0, 1'b0);
  endtask

  task automatic test_reset_mid_and_held_start();
    sel = 1'b0;
    run_to(5, 1'b0);
    repeat (2) tick();
    R_n = 1'b0;
    #1;
    checks++;
    if ({o_state, o_R, o_load, o_hold, o_act, o_busy, o_done, o_rcnt} !== 15'b0000_1_00_0_0000_0_0_00)
      $display("FAIL async_reset: got %h required %h",
               {o_state, o_R, o_load, o_hold, o_act, o_busy, o_done, o_rcnt}, 15'b0000_1_00_0_0000_0_0_00);
    else passed++;
    #1;
    R_n = 1'b1;
    tick();
    checks++;
    if (o_state !== 4'd0)
      $display("FAIL after_reset_idle: got %0d required 0", o_state);
    else passed++;
    run_to(8, 1'b1);
    for (int k = 0; k < 5; k++) begin
      abort = k[0];
      tick();
      checks++;
      if ({o_state, o_done, o_busy} !== {4'd8, 1'b1, 1'b0})
        $display("FAIL held_start_done[%0d]: got %h required %h", k, {o_state, o_done, o_busy}, {4'd8, 1'b1, 1'b0});
      else passed++;
    end
    abort = 1'b0;
    set_start(1'b0);
    tick();
    checks++;
    if ({o_state, o_done} !== {4'd0, 1'b0})
      $display("FAIL release_start: got %h required %h", {o_state, o_done}, {4'd0, 1'b0});
    else passed++;
    tick();
    checks++;
    if ({o_state, o_busy} !== {4'd0, 1'b0})
      $display("FAIL no_restart: got %h required %h", {o_state, o_busy}, {4'd0, 1'b0});
    else passed++;
  endtask

  initial begin
    test_reset();
    test_full_cycle(1'b0);
    test_full_cycle(1'b1);
    test_lid();
    test_abort();
    test_guard_held();
    test_reset_mid_and_held_start();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", passed, checks);
    $fatal(1);
  end

endmodule
